// File: rtl/fft_frame_scheduler_if.sv
// rtl/fft_frame_scheduler_if.sv - sample stream, buffer write bus and FFT handshake bundle
interface fft_frame_scheduler_if #(
   parameter int FFT_POINTS = 512,
   parameter int DATA_WIDTH = 24,
   parameter int CNT_WIDTH  = 16
);
   localparam int AW = $clog2(FFT_POINTS) + 1;

   logic                  i_enable;
   logic                  i_sample_valid;
   logic [DATA_WIDTH-1:0] i_sample;
   logic                  o_buf_wr_en;
   logic [AW-1:0]         o_buf_wr_addr;
   logic [DATA_WIDTH-1:0] o_buf_wr_data;
   logic                  o_read_bank;
   logic                  o_data_ready;
   logic                  i_fft_busy;
   logic                  i_fft_done;
   logic                  i_clear_overrun;
   logic                  o_overrun;
   logic [CNT_WIDTH-1:0]  o_frame_count;
   logic [CNT_WIDTH-1:0]  o_drop_count;

   // scheduler side
   modport slave (
      input  i_enable, i_sample_valid, i_sample, i_fft_busy, i_fft_done, i_clear_overrun,
      output o_buf_wr_en, o_buf_wr_addr, o_buf_wr_data, o_read_bank, o_data_ready,
             o_overrun, o_frame_count, o_drop_count
   );

   // front end / FFT controller side
   modport master (
      output i_enable, i_sample_valid, i_sample, i_fft_busy, i_fft_done, i_clear_overrun,
      input  o_buf_wr_en, o_buf_wr_addr, o_buf_wr_data, o_read_bank, o_data_ready,
             o_overrun, o_frame_count, o_drop_count
   );
endinterface

// File: rtl/fft_frame_scheduler.sv
// rtl/fft_frame_scheduler.sv - ping-pong sample buffer writer and FFT frame hand-off
module fft_frame_scheduler #(
   parameter int FFT_POINTS = 512,
   parameter int DATA_WIDTH = 24,
   parameter int CNT_WIDTH  = 16
) (
   input logic                  clk,
   input logic                  reset_n,
   fft_frame_scheduler_if.slave io_sched
);
   localparam int PW = $clog2(FFT_POINTS);

   typedef enum logic       {W_FILL, W_HOLD} wr_state_t;
   typedef enum logic [1:0] {R_IDLE, R_START, R_BUSY} rd_state_t;

   wr_state_t             r_wr_state, w_wr_state_nxt;
   rd_state_t             r_rd_state, w_rd_state_nxt;
   logic                  r_wr_bank;
   logic [PW-1:0]         r_wr_ptr;
   logic                  r_read_bank;
   logic                  r_full;          // last word of a bank accepted in the previous cycle
   logic                  r_buf_wr_en;
   logic [PW:0]           r_buf_wr_addr;
   logic [DATA_WIDTH-1:0] r_buf_wr_data;
   logic                  r_overrun;
   logic [CNT_WIDTH-1:0]  r_frame_count;
   logic [CNT_WIDTH-1:0]  r_drop_count;
   logic                  w_data_ready;

   logic                  w_in;
   logic                  w_done;
   logic                  w_handoff;
   logic                  w_accept;
   logic                  w_drop;
   logic                  w_bank_eff;
   logic [PW-1:0]         w_ptr_eff;

   assign w_in   = io_sched.i_enable & io_sched.i_sample_valid;
   // done only counts while the FFT actually owns a frame
   assign w_done = (r_rd_state == R_BUSY) & io_sched.i_fft_done;
   // a full bank (just completed or pending) moves to the reader once the reader is free
   assign w_handoff = (r_full | (r_wr_state == W_HOLD)) & ((r_rd_state == R_IDLE) | w_done);
   // in the completion cycle a sample may only land if the other bank was freed right now
   assign w_accept  = w_in & (r_wr_state == W_FILL) & (~r_full | w_handoff);
   assign w_drop    = w_in & ~w_accept;
   assign w_bank_eff = w_handoff ? ~r_wr_bank : r_wr_bank;
   assign w_ptr_eff  = w_handoff ? '0 : r_wr_ptr;

   // state registers for writer and reader FSMs
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_wr_state <= W_FILL;
         r_rd_state <= R_IDLE;
      end else begin
         r_wr_state <= w_wr_state_nxt;
         r_rd_state <= w_rd_state_nxt;
      end
   end

   // next-state logic: writer parks on a full bank, reader walks idle/start/busy
   always_comb begin
      w_wr_state_nxt = r_wr_state;
      w_rd_state_nxt = r_rd_state;
      case (r_wr_state)
         W_FILL:  if (r_full && !w_handoff) w_wr_state_nxt = W_HOLD;
         W_HOLD:  if (w_handoff) w_wr_state_nxt = W_FILL;
         default: w_wr_state_nxt = W_FILL;
      endcase
      case (r_rd_state)
         R_IDLE:  if (w_handoff) w_rd_state_nxt = R_START;
         R_START: if (io_sched.i_fft_busy) w_rd_state_nxt = R_BUSY;
         R_BUSY:  if (io_sched.i_fft_done) w_rd_state_nxt = w_handoff ? R_START : R_IDLE;
         default: w_rd_state_nxt = R_IDLE;
      endcase
   end

   // reader request is asserted only while a handed-off frame awaits the FFT
   always_comb begin
      w_data_ready = 1'b0;
      if (r_rd_state == R_START) w_data_ready = 1'b1;
   end

   // write pointer, bank ownership, buffer write port and statistics
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_wr_bank     <= 1'b0;
         r_wr_ptr      <= '0;
         r_read_bank   <= 1'b0;
         r_full        <= 1'b0;
         r_buf_wr_en   <= 1'b0;
         r_buf_wr_addr <= '0;
         r_buf_wr_data <= '0;
         r_overrun     <= 1'b0;
         r_frame_count <= '0;
         r_drop_count  <= '0;
      end else begin
         r_buf_wr_en <= w_accept;
         r_full      <= w_accept & (w_ptr_eff == PW'(FFT_POINTS - 1));
         if (w_accept) begin
            r_buf_wr_addr <= {w_bank_eff, w_ptr_eff};
            r_buf_wr_data <= io_sched.i_sample;
         end
         if (!io_sched.i_enable)
            r_wr_ptr <= '0;
         else if (w_accept)
            r_wr_ptr <= w_ptr_eff + PW'(1);
         else
            r_wr_ptr <= w_ptr_eff;
         if (w_handoff) begin
            r_read_bank   <= r_wr_bank;
            r_wr_bank     <= ~r_wr_bank;
            r_frame_count <= r_frame_count + CNT_WIDTH'(1);
         end
         if (w_drop && (r_drop_count != '1))
            r_drop_count <= r_drop_count + CNT_WIDTH'(1);
         if (w_drop)
            r_overrun <= 1'b1;
         else if (io_sched.i_clear_overrun)
            r_overrun <= 1'b0;
      end
   end

   assign io_sched.o_buf_wr_en   = r_buf_wr_en;
   assign io_sched.o_buf_wr_addr = r_buf_wr_addr;
   assign io_sched.o_buf_wr_data = r_buf_wr_data;
   assign io_sched.o_read_bank   = r_read_bank;
   assign io_sched.o_data_ready  = w_data_ready;
   assign io_sched.o_overrun     = r_overrun;
   assign io_sched.o_frame_count = r_frame_count;
   assign io_sched.o_drop_count  = r_drop_count;
endmodule

// File: tb/tb_fft_frame_scheduler.sv
// tb/tb_fft_frame_scheduler.sv - directed bench for fft_frame_scheduler with FFT_POINTS=8
module tb_fft_frame_scheduler;
   logic clk = 1'b0;
   logic reset_n = 1'b0;
   int   n_vec = 0;
   int   n_err = 0;

   always #5 clk = ~clk;

   fft_frame_scheduler_if #(.FFT_POINTS(8), .DATA_WIDTH(24), .CNT_WIDTH(16)) sif ();

   fft_frame_scheduler #(.FFT_POINTS(8), .DATA_WIDTH(24), .CNT_WIDTH(16)) dut (
      .clk      (clk),
      .reset_n  (reset_n),
      .io_sched (sif)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic chk_wr(input string tag, input int addr, input int data);
      chk({tag, "_en"},   32'(sif.o_buf_wr_en), 32'd1);
      chk({tag, "_addr"}, 32'(sif.o_buf_wr_addr), 32'(addr));
      chk({tag, "_data"}, 32'(sif.o_buf_wr_data), 32'(data));
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_wr_en"},   32'(sif.o_buf_wr_en), 32'd0);
      chk({tag, "_wr_addr"}, 32'(sif.o_buf_wr_addr), 32'd0);
      chk({tag, "_wr_data"}, 32'(sif.o_buf_wr_data), 32'd0);
      chk({tag, "_rbank"},   32'(sif.o_read_bank), 32'd0);
      chk({tag, "_ready"},   32'(sif.o_data_ready), 32'd0);
      chk({tag, "_ovr"},     32'(sif.o_overrun), 32'd0);
      chk({tag, "_frames"},  32'(sif.o_frame_count), 32'd0);
      chk({tag, "_drops"},   32'(sif.o_drop_count), 32'd0);
   endtask

   initial begin
      sif.i_enable        = 1'b1;
      sif.i_sample_valid  = 1'b0;
      sif.i_sample        = '0;
      sif.i_fft_busy      = 1'b0;
      sif.i_fft_done      = 1'b0;
      sif.i_clear_overrun = 1'b0;

      // reset state
      tick(); tick();
      chk_all_zero("rst");
      reset_n = 1'b1;

      // frame 1 into bank 0: addresses 0..7, data 1..8
      for (int i = 0; i < 8; i++) begin
         sif.i_sample_valid = 1'b1;
         sif.i_sample = 24'(i + 1);
         tick();
         chk_wr("f1", i, i + 1);
      end
      sif.i_sample_valid = 1'b0;
      chk("f1_ready_k1", 32'(sif.o_data_ready), 32'd0);
      tick();
      chk("f1_ready_k2", 32'(sif.o_data_ready), 32'd1);
      chk("f1_rbank",    32'(sif.o_read_bank), 32'd0);
      chk("f1_frames",   32'(sif.o_frame_count), 32'd1);

      // request held while busy stays low
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("hold_ready", 32'(sif.o_data_ready), 32'd1);
      end
      sif.i_fft_busy = 1'b1;
      tick();
      chk("busy_ready", 32'(sif.o_data_ready), 32'd0);

      // frame 2 into bank 1, FFT finishes after 3 samples
      for (int i = 0; i < 8; i++) begin
         sif.i_sample_valid = 1'b1;
         sif.i_sample = 24'(9 + i);
         if (i == 3) begin
            sif.i_fft_done = 1'b1;
            sif.i_fft_busy = 1'b0;
         end
         tick();
         sif.i_fft_done = 1'b0;
         chk_wr("f2", 8 + i, 9 + i);
      end
      sif.i_sample_valid = 1'b0;
      tick();
      chk("f2_rbank",  32'(sif.o_read_bank), 32'd1);
      chk("f2_frames", 32'(sif.o_frame_count), 32'd2);
      chk("f2_drops",  32'(sif.o_drop_count), 32'd0);
      chk("f2_ready",  32'(sif.o_data_ready), 32'd1);
      sif.i_fft_busy = 1'b1;
      tick();

      // frame 3 into bank 0 while FFT stays busy: bank stays pending
      for (int i = 0; i < 8; i++) begin
         sif.i_sample_valid = 1'b1;
         sif.i_sample = 24'(17 + i);
         tick();
         chk_wr("f3", i, 17 + i);
      end
      sif.i_sample_valid = 1'b0;
      tick();
      chk("hold_frames", 32'(sif.o_frame_count), 32'd2);
      chk("hold_rbank",  32'(sif.o_read_bank), 32'd1);

      // 8 dropped samples, the last with a simultaneous overrun clear
      for (int i = 0; i < 8; i++) begin
         sif.i_sample_valid = 1'b1;
         sif.i_sample = 24'(40 + i);
         sif.i_clear_overrun = (i == 7);
         tick();
         chk("drop_en", 32'(sif.o_buf_wr_en), 32'd0);
      end
      sif.i_clear_overrun = 1'b0;
      chk("drop_count8", 32'(sif.o_drop_count), 32'd8);
      chk("ovr_set_wins", 32'(sif.o_overrun), 32'd1);

      // done releases bank 1; sample in the same cycle is still dropped
      sif.i_fft_done = 1'b1;
      sif.i_fft_busy = 1'b0;
      sif.i_sample = 24'h0000aa;
      tick();
      sif.i_fft_done = 1'b0;
      chk("rel_drop9",  32'(sif.o_drop_count), 32'd9);
      chk("rel_en",     32'(sif.o_buf_wr_en), 32'd0);
      chk("rel_frames", 32'(sif.o_frame_count), 32'd3);
      chk("rel_rbank",  32'(sif.o_read_bank), 32'd0);
      chk("rel_ready",  32'(sif.o_data_ready), 32'd1);
      sif.i_sample = 24'h000100;
      tick();
      chk_wr("resume", 8, 'h100);
      sif.i_sample_valid = 1'b0;
      sif.i_clear_overrun = 1'b1;
      sif.i_fft_busy = 1'b1;
      tick();
      sif.i_clear_overrun = 1'b0;
      chk("ovr_clear", 32'(sif.o_overrun), 32'd0);
      chk("busy2_ready", 32'(sif.o_data_ready), 32'd0);

      // bank 1 completes in the same cycle FFT is done: immediate hand-off
      for (int i = 1; i < 8; i++) begin
         sif.i_sample_valid = 1'b1;
         sif.i_sample = 24'('h100 + i);
         tick();
         chk_wr("f4", 8 + i, 'h100 + i);
      end
      sif.i_sample = 24'h000200;
      sif.i_fft_done = 1'b1;
      sif.i_fft_busy = 1'b0;
      tick();
      sif.i_fft_done = 1'b0;
      chk_wr("simul", 0, 'h200);
      chk("simul_drops",  32'(sif.o_drop_count), 32'd9);
      chk("simul_frames", 32'(sif.o_frame_count), 32'd4);
      chk("simul_rbank",  32'(sif.o_read_bank), 32'd1);
      chk("simul_ready",  32'(sif.o_data_ready), 32'd1);

      // advance to wr_ptr=5 in bank 0, then reset asynchronously
      for (int i = 1; i < 5; i++) begin
         sif.i_sample = 24'('h200 + i);
         tick();
      end
      sif.i_sample_valid = 1'b0;
      chk("pre_rst_en", 32'(sif.o_buf_wr_en), 32'd1);
      #2 reset_n = 1'b0;
      #1 chk_all_zero("arst");
      tick();
      reset_n = 1'b1;
      sif.i_sample_valid = 1'b1;
      sif.i_sample = 24'h000300;
      tick();
      chk_wr("post_rst", 0, 'h300);

      // enable low discards the partial frame
      sif.i_sample = 24'h000301;
      tick();
      chk_wr("en_pre", 1, 'h301);
      sif.i_enable = 1'b0;
      tick();
      chk("en_off", 32'(sif.o_buf_wr_en), 32'd0);
      sif.i_enable = 1'b1;
      sif.i_sample = 24'h000302;
      tick();
      chk_wr("en_restart", 0, 'h302);
      chk("en_drops", 32'(sif.o_drop_count), 32'd0);
      sif.i_sample_valid = 1'b0;
      tick();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
